// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage.
// Holds the datapath width default, field widths, the bit positions
// inside the 8-bit control word, the NOP control value, and a helper
// that detects a dependency of a decode-stage source on the EX stage.
package id_ex_stage_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_IDX_W    = 5;
  localparam int CTRL_W       = 8;
  localparam int CNT_W        = 16;

  // Control word bit positions; bits 7:4 are opaque and only passed along.
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_USES_RS1  = 2;
  localparam int CTRL_USES_RS2  = 3;

  localparam logic [CTRL_W-1:0] CTRL_NOP       = '0;
  localparam logic [CNT_W-1:0]  BUBBLE_CNT_MAX = '1;

  // True when the instruction sitting in EX writes the register that a
  // decode-stage source reads (x0 never counts as a dependency).
  function automatic logic ex_dependency(
    input logic                 ex_valid,
    input logic [CTRL_W-1:0]    ex_ctrl,
    input logic [REG_IDX_W-1:0] ex_rd,
    input logic [REG_IDX_W-1:0] src_index,
    input logic                 src_used
  );
    return ex_valid && ex_ctrl[CTRL_REG_WRITE] && (ex_rd != '0) &&
           (ex_rd == src_index) && src_used;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of all signals crossing the ID/EX stage boundary.
//   master : drives the decode slot, bypass sources and flush; observes
//            stall_out, the EX register contents and bubble_count.
//   slave  : the id_ex_stage block itself.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  // Decode slot
  logic                 id_valid;
  logic [XLEN-1:0]      id_pc;
  logic [XLEN-1:0]      id_imm;
  logic [REG_IDX_W-1:0] id_rs1_index;
  logic [REG_IDX_W-1:0] id_rs2_index;
  logic [REG_IDX_W-1:0] id_rd_index;
  logic [XLEN-1:0]      id_rs1_data;
  logic [XLEN-1:0]      id_rs2_data;
  logic [CTRL_W-1:0]    id_ctrl;

  // Bypass sources
  logic                 mem_wb_en;
  logic [REG_IDX_W-1:0] mem_rd;
  logic [XLEN-1:0]      mem_result;
  logic                 wb_en;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;

  logic                 flush;
  logic                 stall_out;

  // ID/EX register contents
  logic                 ex_valid;
  logic [XLEN-1:0]      ex_pc;
  logic [XLEN-1:0]      ex_rs1_data;
  logic [XLEN-1:0]      ex_rs2_data;
  logic [XLEN-1:0]      ex_imm;
  logic [REG_IDX_W-1:0] ex_rd_index;
  logic [CTRL_W-1:0]    ex_ctrl;
  logic                 ex_fwd_rs1;
  logic                 ex_fwd_rs2;
  logic [CNT_W-1:0]     bubble_count;

  modport master (
    output id_valid, id_pc, id_imm, id_rs1_index, id_rs2_index, id_rd_index,
           id_rs1_data, id_rs2_data, id_ctrl,
           mem_wb_en, mem_rd, mem_result, wb_en, wb_rd, wb_data, flush,
    input  stall_out, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rd_index, ex_ctrl, ex_fwd_rs1, ex_fwd_rs2, bubble_count
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1_index, id_rs2_index, id_rd_index,
           id_rs1_data, id_rs2_data, id_ctrl,
           mem_wb_en, mem_rd, mem_result, wb_en, wb_rd, wb_data, flush,
    output stall_out, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rd_index, ex_ctrl, ex_fwd_rs1, ex_fwd_rs2, bubble_count
  );

endinterface

// File: rtl/id_ex_stage_operand_fwd_mux.sv
// Operand select for one decode-stage source register.
//   index_i                    : source register index
//   rf_data_i                  : register-file read data for that index
//   mem_wb_en_i/mem_rd_i/mem_result_i : MEM-stage writer (final value)
//   wb_en_i/wb_rd_i/wb_data_i  : writeback port, same cycle as the RF write
//   operand_o                  : value to capture into ID/EX
// Priority: x0 -> 0, then MEM (younger), then WB, then the register file.
// The WB leg covers the write that lands in the register file on this
// very edge and therefore is not yet visible on the read port.
module operand_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [REG_IDX_W-1:0] index_i,
  input  logic [XLEN-1:0]      rf_data_i,
  input  logic                 mem_wb_en_i,
  input  logic [REG_IDX_W-1:0] mem_rd_i,
  input  logic [XLEN-1:0]      mem_result_i,
  input  logic                 wb_en_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]      wb_data_i,
  output logic [XLEN-1:0]      operand_o
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // output unassigned, which would infer a latch.
    operand_o = rf_data_i;
    if (index_i == '0) begin
      operand_o = '0;
    end else if (mem_wb_en_i && (mem_rd_i == index_i)) begin
      operand_o = mem_result_i;
    end else if (wb_en_i && (wb_rd_i == index_i)) begin
      operand_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass and load-use interlock.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : id_ex_stage_if.slave -- decode slot, MEM/WB bypass sources,
//            flush in; stall_out, EX register contents, forward-from-EX
//            flags and the saturating stall-bubble counter out.
// A dependency on a load in EX stalls exactly one cycle; a dependency on
// any other writer in EX is flagged so EX can reuse its own last result.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            dep_rs1;
  logic            dep_rs2;
  logic            load_use;
  logic            stall;

  logic                 ex_valid_q,    ex_valid_d;
  logic [XLEN-1:0]      ex_pc_q,       ex_pc_d;
  logic [XLEN-1:0]      ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]      ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]      ex_imm_q,      ex_imm_d;
  logic [REG_IDX_W-1:0] ex_rd_index_q, ex_rd_index_d;
  logic [CTRL_W-1:0]    ex_ctrl_q,     ex_ctrl_d;
  logic                 ex_fwd_rs1_q,  ex_fwd_rs1_d;
  logic                 ex_fwd_rs2_q,  ex_fwd_rs2_d;
  logic [CNT_W-1:0]     bubble_count_q, bubble_count_d;

  operand_fwd_mux #(.XLEN(XLEN)) u_rs1_mux (
    .index_i      (bus.id_rs1_index),
    .rf_data_i    (bus.id_rs1_data),
    .mem_wb_en_i  (bus.mem_wb_en),
    .mem_rd_i     (bus.mem_rd),
    .mem_result_i (bus.mem_result),
    .wb_en_i      (bus.wb_en),
    .wb_rd_i      (bus.wb_rd),
    .wb_data_i    (bus.wb_data),
    .operand_o    (rs1_fwd)
  );

  operand_fwd_mux #(.XLEN(XLEN)) u_rs2_mux (
    .index_i      (bus.id_rs2_index),
    .rf_data_i    (bus.id_rs2_data),
    .mem_wb_en_i  (bus.mem_wb_en),
    .mem_rd_i     (bus.mem_rd),
    .mem_result_i (bus.mem_result),
    .wb_en_i      (bus.wb_en),
    .wb_rd_i      (bus.wb_rd),
    .wb_data_i    (bus.wb_data),
    .operand_o    (rs2_fwd)
  );

  assign dep_rs1 = ex_dependency(ex_valid_q, ex_ctrl_q, ex_rd_index_q,
                                 bus.id_rs1_index, bus.id_ctrl[CTRL_USES_RS1]);
  assign dep_rs2 = ex_dependency(ex_valid_q, ex_ctrl_q, ex_rd_index_q,
                                 bus.id_rs2_index, bus.id_ctrl[CTRL_USES_RS2]);

  // Load data only exists once the load reaches MEM, so a consumer right
  // behind it must wait one cycle and then pick it up through the MEM bypass.
  assign load_use = bus.id_valid && ex_ctrl_q[CTRL_MEM_READ] && (dep_rs1 || dep_rs2);
  assign stall    = rst_n && load_use;

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_pc_d        = ex_pc_q;
    ex_rs1_data_d  = ex_rs1_data_q;
    ex_rs2_data_d  = ex_rs2_data_q;
    ex_imm_d       = ex_imm_q;
    ex_rd_index_d  = ex_rd_index_q;
    ex_ctrl_d      = ex_ctrl_q;
    ex_fwd_rs1_d   = ex_fwd_rs1_q;
    ex_fwd_rs2_d   = ex_fwd_rs2_q;
    bubble_count_d = bubble_count_q;

    if (bus.flush || stall) begin
      // Bubble: only the qualifying fields are cleared, the data fields hold.
      ex_valid_d   = 1'b0;
      ex_ctrl_d    = CTRL_NOP;
      ex_fwd_rs1_d = 1'b0;
      ex_fwd_rs2_d = 1'b0;
    end else begin
      ex_valid_d    = bus.id_valid;
      ex_pc_d       = bus.id_pc;
      ex_rs1_data_d = rs1_fwd;
      ex_rs2_data_d = rs2_fwd;
      ex_imm_d      = bus.id_imm;
      ex_rd_index_d = bus.id_rd_index;
      ex_ctrl_d     = bus.id_valid ? bus.id_ctrl : CTRL_NOP;
      ex_fwd_rs1_d  = bus.id_valid && dep_rs1;
      ex_fwd_rs2_d  = bus.id_valid && dep_rs2;
    end

    // Only bubbles caused by the interlock are counted; a flush wins the slot.
    if (stall && !bus.flush && (bubble_count_q != BUBBLE_CNT_MAX)) begin
      bubble_count_d = bubble_count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data fields are cleared as well, not just the valid/ctrl
      // qualifiers, so the EX outputs are fully defined straight out of reset.
      ex_valid_q     <= 1'b0;
      ex_pc_q        <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_imm_q       <= '0;
      ex_rd_index_q  <= '0;
      ex_ctrl_q      <= CTRL_NOP;
      ex_fwd_rs1_q   <= 1'b0;
      ex_fwd_rs2_q   <= 1'b0;
      bubble_count_q <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_pc_q        <= ex_pc_d;
      ex_rs1_data_q  <= ex_rs1_data_d;
      ex_rs2_data_q  <= ex_rs2_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_rd_index_q  <= ex_rd_index_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_fwd_rs1_q   <= ex_fwd_rs1_d;
      ex_fwd_rs2_q   <= ex_fwd_rs2_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.stall_out    = stall;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_pc        = ex_pc_q;
  assign bus.ex_rs1_data  = ex_rs1_data_q;
  assign bus.ex_rs2_data  = ex_rs2_data_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_rd_index  = ex_rd_index_q;
  assign bus.ex_ctrl      = ex_ctrl_q;
  assign bus.ex_fwd_rs1   = ex_fwd_rs1_q;
  assign bus.ex_fwd_rs2   = ex_fwd_rs2_q;
  assign bus.bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX register contents are
// queued when the decode slot is driven and compared one cycle later.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [15:0] exp_bubbles;

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        valid;
    logic [7:0]  ctrl;
    logic        fwd1;
    logic        fwd2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        check_data;
  } exp_t;

  exp_t sb_q[$];

  // Reference operand select: x0, then MEM, then WB, then register file.
  function automatic logic [31:0] ref_op(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (bus.mem_wb_en && bus.mem_rd == idx) return bus.mem_result;
    if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
    return rf;
  endfunction

  task automatic set_id(input logic v, input logic [31:0] pc,
                        input logic [4:0] rs1, input logic [31:0] rs1d,
                        input logic [4:0] rs2, input logic [31:0] rs2d,
                        input logic [4:0] rd, input logic [7:0] ctrl,
                        input logic [31:0] imm);
    bus.id_valid     = v;
    bus.id_pc        = pc;
    bus.id_rs1_index = rs1;
    bus.id_rs1_data  = rs1d;
    bus.id_rs2_index = rs2;
    bus.id_rs2_data  = rs2d;
    bus.id_rd_index  = rd;
    bus.id_ctrl      = ctrl;
    bus.id_imm       = imm;
  endtask

  task automatic set_bypass(input logic men, input logic [4:0] mrd, input logic [31:0] mres,
                            input logic wen, input logic [4:0] wrd, input logic [31:0] wdat);
    bus.mem_wb_en  = men;
    bus.mem_rd     = mrd;
    bus.mem_result = mres;
    bus.wb_en      = wen;
    bus.wb_rd      = wrd;
    bus.wb_data    = wdat;
  endtask

  task automatic push_capture(input string name, input logic f1, input logic f2,
                              input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    e.name = name;
    e.valid = bus.id_valid;
    e.ctrl = bus.id_valid ? bus.id_ctrl : 8'h00;
    e.fwd1 = f1;
    e.fwd2 = f2;
    e.pc = bus.id_pc;
    e.imm = bus.id_imm;
    e.rs1 = rs1;
    e.rs2 = rs2;
    e.rd = bus.id_rd_index;
    e.check_data = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic push_bubble(input string name);
    exp_t e;
    e.name = name;
    e.valid = 1'b0;
    e.ctrl = 8'h00;
    e.fwd1 = 1'b0;
    e.fwd2 = 1'b0;
    e.pc = '0;
    e.imm = '0;
    e.rs1 = '0;
    e.rs2 = '0;
    e.rd = '0;
    e.check_data = 1'b0;
    sb_q.push_back(e);
  endtask

  // Advance one edge and score the oldest expectation against the EX register.
  task automatic tick_and_score();
    exp_t e;
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: edge with no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    if (bus.ex_valid !== e.valid) begin
      n_bad++; $display("FAIL %s ex_valid got %0b want %0b", e.name, bus.ex_valid, e.valid);
    end
    n_cmp++;
    if (bus.ex_ctrl !== e.ctrl) begin
      n_bad++; $display("FAIL %s ex_ctrl got %h want %h", e.name, bus.ex_ctrl, e.ctrl);
    end
    n_cmp++;
    if (bus.ex_fwd_rs1 !== e.fwd1 || bus.ex_fwd_rs2 !== e.fwd2) begin
      n_bad++; $display("FAIL %s ex_fwd got %0b%0b want %0b%0b", e.name,
                        bus.ex_fwd_rs1, bus.ex_fwd_rs2, e.fwd1, e.fwd2);
    end
    if (e.check_data) begin
      n_cmp++;
      if (bus.ex_rs1_data !== e.rs1) begin
        n_bad++; $display("FAIL %s ex_rs1_data got %h want %h", e.name, bus.ex_rs1_data, e.rs1);
      end
      n_cmp++;
      if (bus.ex_rs2_data !== e.rs2) begin
        n_bad++; $display("FAIL %s ex_rs2_data got %h want %h", e.name, bus.ex_rs2_data, e.rs2);
      end
      n_cmp++;
      if (bus.ex_pc !== e.pc || bus.ex_imm !== e.imm || bus.ex_rd_index !== e.rd) begin
        n_bad++; $display("FAIL %s pc/imm/rd got %h/%h/%0d want %h/%h/%0d", e.name,
                          bus.ex_pc, bus.ex_imm, bus.ex_rd_index, e.pc, e.imm, e.rd);
      end
    end
  endtask

  // Empty decode slot, no bypass, no flush: leaves EX holding a non-writer.
  task automatic idle_cycle();
    bus.flush = 1'b0;
    set_bypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 8'h00, 32'h0);
    push_capture("idle", 1'b0, 1'b0, 32'h0, 32'h0);
    tick_and_score();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    set_bypass(1'b1, 5'd3, 32'hCAFE, 1'b1, 5'd4, 32'hBEEF);
    set_id(1'b1, 32'h80, 5'd3, 32'h1, 5'd4, 32'h2, 5'd9, 8'hFF, 32'h7);
    #3;
    n_cmp++;
    if ({bus.ex_valid, bus.ex_ctrl, bus.ex_fwd_rs1, bus.ex_fwd_rs2, bus.ex_rd_index,
         bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.bubble_count} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got valid=%0b ctrl=%h pc=%h cnt=%h want all zero",
                        bus.ex_valid, bus.ex_ctrl, bus.ex_pc, bus.bubble_count);
    end
    n_cmp++;
    if (bus.stall_out !== 1'b0) begin
      n_bad++; $display("FAIL reset_stall got %0b want 0", bus.stall_out);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00) begin
      n_bad++; $display("FAIL reset_held_over_edge got valid=%0b ctrl=%h want 0/00",
                        bus.ex_valid, bus.ex_ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_bubbles = 16'h0;
  endtask

  task automatic test_wb_bypass();
    idle_cycle();
    set_bypass(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAA);
    set_id(1'b1, 32'h100, 5'd5, 32'h11, 5'd6, 32'h66, 5'd10, 8'h0D, 32'h4);
    #1;
    n_cmp++;
    if (bus.stall_out !== 1'b0) begin
      n_bad++; $display("FAIL wb_bypass_stall got %0b want 0", bus.stall_out);
    end
    push_capture("wb_bypass", 1'b0, 1'b0, 32'hAA, 32'h66);
    tick_and_score();
  endtask

  task automatic test_mem_priority();
    set_bypass(1'b1, 5'd5, 32'h22, 1'b1, 5'd5, 32'h33);
    set_id(1'b1, 32'h104, 5'd5, 32'h11, 5'd5, 32'h11, 5'd11, 8'h0D, 32'h8);
    push_capture("mem_over_wb", 1'b0, 1'b0, 32'h22, 32'h22);
    tick_and_score();
    set_bypass(1'b1, 5'd6, 32'h44, 1'b1, 5'd5, 32'h33);
    set_id(1'b1, 32'h108, 5'd5, 32'h11, 5'd6, 32'h66, 5'd12, 8'hAD, 32'hC);
    push_capture("mem_and_wb_split", 1'b0, 1'b0, 32'h33, 32'h44);
    tick_and_score();
  endtask

  task automatic test_id_invalid();
    idle_cycle();
    set_id(1'b0, 32'h140, 5'd1, 32'h10, 5'd2, 32'h20, 5'd3, 8'hFF, 32'h5);
    push_capture("invalid_ctrl_zero", 1'b0, 1'b0, 32'h10, 32'h20);
    tick_and_score();
    set_id(1'b1, 32'h144, 5'd1, 32'h10, 5'd0, 32'h0, 5'd7, 8'h07, 32'h0);
    push_capture("load_x7", 1'b0, 1'b0, 32'h10, 32'h0);
    tick_and_score();
    set_id(1'b0, 32'h148, 5'd1, 32'h10, 5'd7, 32'h70, 5'd8, 8'h08, 32'h0);
    #1;
    n_cmp++;
    if (bus.stall_out !== 1'b0) begin
      n_bad++; $display("FAIL invalid_no_stall got %0b want 0", bus.stall_out);
    end
    push_capture("invalid_behind_load", 1'b0, 1'b0, 32'h10, 32'h70);
    tick_and_score();
  endtask

  task automatic test_load_use();
    idle_cycle();
    set_id(1'b1, 32'h200, 5'd1, 32'h1000, 5'd0, 32'h0, 5'd7, 8'h07, 32'h10);
    push_capture("lu_load", 1'b0, 1'b0, 32'h1000, 32'h0);
    tick_and_score();
    set_id(1'b1, 32'h204, 5'd2, 32'h2, 5'd7, 32'hBAD, 5'd8, 8'h09, 32'h0);
    #1;
    n_cmp++;
    if (bus.stall_out !== 1'b1) begin
      n_bad++; $display("FAIL lu_stall got %0b want 1", bus.stall_out);
    end
    push_bubble("lu_bubble");
    tick_and_score();
    exp_bubbles = exp_bubbles + 16'd1;
    n_cmp++;
    if (bus.bubble_count !== exp_bubbles) begin
      n_bad++; $display("FAIL lu_count got %h want %h", bus.bubble_count, exp_bubbles);
    end
    set_bypass(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
    #1;
    n_cmp++;
    if (bus.stall_out !== 1'b0) begin
      n_bad++; $display("FAIL lu_single_cycle got %0b want 0", bus.stall_out);
    end
    push_capture("lu_mem_data", 1'b0, 1'b0, 32'h2, 32'h77);
    tick_and_score();
    n_cmp++;
    if (bus.bubble_count !== exp_bubbles) begin
      n_bad++; $display("FAIL lu_count_after got %h want %h", bus.bubble_count, exp_bubbles);
    end
    // Load in EX but the ID instruction does not actually use rs1=x7.
    idle_cycle();
    set_id(1'b1, 32'h210, 5'd1, 32'h1, 5'd0, 32'h0, 5'd7, 8'h03, 32'h0);
    push_capture("lu_load2", 1'b0, 1'b0, 32'h1, 32'h0);
    tick_and_score();
    set_id(1'b1, 32'h214, 5'd7, 32'h70, 5'd0, 32'h0, 5'd9, 8'h01, 32'h0);
    #1;
    n_cmp++;
    if (bus.stall_out !== 1'b0) begin
      n_bad++; $display("FAIL lu_unused_src got %0b want 0", bus.stall_out);
    end
    push_capture("lu_unused_src", 1'b0, 1'b0, 32'h70, 32'h0);
    tick_and_score();
  endtask

  task automatic test_ex_fwd();
    idle_cycle();
    set_id(1'b1, 32'h300, 5'd1, 32'h5, 5'd2, 32'h6, 5'd3, 8'h0D, 32'h0);
    push_capture("add_x3", 1'b0, 1'b0, 32'h5, 32'h6);
    tick_and_score();
    set_id(1'b1, 32'h304, 5'd3, 32'h33, 5'd4, 32'h44, 5'd3, 8'h0D, 32'h0);
    #1;
    n_cmp++;
    if (bus.stall_out !== 1'b0) begin
      n_bad++; $display("FAIL fwd_no_stall got %0b want 0", bus.stall_out);
    end
    push_capture("fwd_rs1", 1'b1, 1'b0, 32'h33, 32'h44);
    tick_and_score();
    set_id(1'b1, 32'h308, 5'd5, 32'h55, 5'd3, 32'h33, 5'd9, 8'h0D, 32'h0);
    push_capture("fwd_rs2", 1'b0, 1'b1, 32'h55, 32'h33);
    tick_and_score();
    set_id(1'b1, 32'h30C, 5'd9, 32'h99, 5'd9, 32'h99, 5'd0, 8'h0C, 32'h0);
    push_capture("fwd_both", 1'b1, 1'b1, 32'h99, 32'h99);
    tick_and_score();
  endtask

  task automatic test_x0();
    idle_cycle();
    set_id(1'b1, 32'h400, 5'd1, 32'h1, 5'd2, 32'h2, 5'd0, 8'h03, 32'h0);
    push_capture("load_x0", 1'b0, 1'b0, 32'h1, 32'h2);
    tick_and_score();
    set_bypass(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    set_id(1'b1, 32'h404, 5'd0, 32'h1234, 5'd0, 32'h5678, 5'd0, 8'h0D, 32'h0);
    #1;
    n_cmp++;
    if (bus.stall_out !== 1'b0) begin
      n_bad++; $display("FAIL x0_no_stall got %0b want 0", bus.stall_out);
    end
    push_capture("x0_operands", 1'b0, 1'b0, 32'h0, 32'h0);
    tick_and_score();
    set_id(1'b1, 32'h408, 5'd0, 32'h1, 5'd0, 32'h2, 5'd4, 8'h0C, 32'h0);
    push_capture("x0_behind_alu_x0", 1'b0, 1'b0, 32'h0, 32'h0);
    tick_and_score();
  endtask

  task automatic test_flush();
    idle_cycle();
    set_id(1'b1, 32'h500, 5'd1, 32'h1, 5'd0, 32'h0, 5'd9, 8'h03, 32'h0);
    push_capture("fl_load_x9", 1'b0, 1'b0, 32'h1, 32'h0);
    tick_and_score();
    set_id(1'b1, 32'h504, 5'd9, 32'h90, 5'd0, 32'h0, 5'd10, 8'h05, 32'h0);
    bus.flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.stall_out !== 1'b1) begin
      n_bad++; $display("FAIL flush_stall_visible got %0b want 1", bus.stall_out);
    end
    push_bubble("flush_and_stall");
    tick_and_score();
    n_cmp++;
    if (bus.bubble_count !== exp_bubbles) begin
      n_bad++; $display("FAIL flush_count got %h want %h", bus.bubble_count, exp_bubbles);
    end
    bus.flush = 1'b0;
    push_capture("after_flush", 1'b0, 1'b0, 32'h90, 32'h0);
    tick_and_score();
    set_id(1'b1, 32'h508, 5'd1, 32'h1, 5'd2, 32'h2, 5'd11, 8'h0D, 32'h0);
    bus.flush = 1'b1;
    push_bubble("flush_plain");
    tick_and_score();
    bus.flush = 1'b0;
    n_cmp++;
    if (bus.bubble_count !== exp_bubbles) begin
      n_bad++; $display("FAIL flush_plain_count got %h want %h", bus.bubble_count, exp_bubbles);
    end
  endtask

  // One load-use pair: load x7, dependent consumer stalls, consumer captured.
  task automatic load_use_pair(input int k);
    set_bypass(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, 32'h600 + 32'(k), 5'd1, 32'h1, 5'd0, 32'h0, 5'd7, 8'h03, 32'h0);
    push_capture("bc_load", 1'b0, 1'b0, 32'h1, 32'h0);
    tick_and_score();
    set_id(1'b1, 32'h700 + 32'(k), 5'd0, 32'h0, 5'd7, 32'h70, 5'd8, 8'h08, 32'h0);
    push_bubble("bc_bubble");
    tick_and_score();
    if (exp_bubbles != 16'hFFFF) exp_bubbles = exp_bubbles + 16'd1;
    n_cmp++;
    if (bus.bubble_count !== exp_bubbles) begin
      n_bad++; $display("FAIL bubble_count[%0d] got %h want %h", k, bus.bubble_count, exp_bubbles);
    end
    push_capture("bc_consumer", 1'b0, 1'b0, 32'h0, ref_op(5'd7, 32'h70));
    tick_and_score();
  endtask

  task automatic test_bubble_count();
    idle_cycle();
    for (int k = 0; k < 20; k++) load_use_pair(k);
    // Jump close to saturation instead of spending 65k stalls getting there.
    force dut.bubble_count_q = 16'hFFFE;
    #1;
    release dut.bubble_count_q;
    exp_bubbles = 16'hFFFE;
    load_use_pair(100);
    load_use_pair(101);
  endtask

  task automatic test_reset_mid_stall();
    idle_cycle();
    set_id(1'b1, 32'h800, 5'd1, 32'h1, 5'd0, 32'h0, 5'd7, 8'h03, 32'h0);
    push_capture("rs_load", 1'b0, 1'b0, 32'h1, 32'h0);
    tick_and_score();
    set_id(1'b1, 32'h804, 5'd0, 32'h0, 5'd7, 32'h71, 5'd8, 8'h08, 32'h0);
    #1;
    n_cmp++;
    if (bus.stall_out !== 1'b1) begin
      n_bad++; $display("FAIL rs_stall_before got %0b want 1", bus.stall_out);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ex_valid, bus.ex_ctrl, bus.ex_fwd_rs1, bus.ex_fwd_rs2, bus.ex_rd_index,
         bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.bubble_count} !== '0) begin
      n_bad++; $display("FAIL rs_async_clear got valid=%0b ctrl=%h pc=%h cnt=%h want all zero",
                        bus.ex_valid, bus.ex_ctrl, bus.ex_pc, bus.bubble_count);
    end
    n_cmp++;
    if (bus.stall_out !== 1'b0) begin
      n_bad++; $display("FAIL rs_stall_in_reset got %0b want 0", bus.stall_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_bubbles = 16'h0;
    #1;
    n_cmp++;
    if (bus.stall_out !== 1'b0) begin
      n_bad++; $display("FAIL rs_stall_after got %0b want 0", bus.stall_out);
    end
    push_capture("rs_first_capture", 1'b0, 1'b0, 32'h0, 32'h71);
    tick_and_score();
    n_cmp++;
    if (bus.bubble_count !== exp_bubbles) begin
      n_bad++; $display("FAIL rs_count got %h want %h", bus.bubble_count, exp_bubbles);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_bubbles = 16'h0;
    test_reset();
    test_wb_bypass();
    test_mem_priority();
    test_id_invalid();
    test_load_use();
    test_ex_fwd();
    test_x0();
    test_flush();
    test_bubble_count();
    test_reset_mid_stall();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 id_valid  in  1  decode slot holds a real instruction.
REQ-005 id_pc, id_imm  in  XLEN each  decoded PC and immediate.
REQ-006 id_rs1_index, id_rs2_index, id_rd_index  in  5 each  register indices.
REQ-007 id_rs1_data, id_rs2_data  in  XLEN each  register-file read data (combinational read).
REQ-008 id_ctrl  in  8  bit0 reg_write, bit1 mem_read, bit2 uses_rs1, bit3 uses_rs2, bits7:4 opaque, passed through.
REQ-009 mem_wb_en, mem_rd, mem_result  in  1/5/XLEN  MEM-stage writer; mem_result is final, load data included.
REQ-010 wb_en, wb_rd, wb_data  in  1/5/XLEN  writeback port, the same one driving the register file.
REQ-011 flush  in  1  kill the instruction entering EX.
REQ-012 stall_out  out  1  combinational; holds PC/IF/ID upstream.
REQ-013 ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd_index, ex_ctrl  out  ID/EX pipeline register contents.
REQ-014 ex_fwd_rs1, ex_fwd_rs2  out  1 each  EX shall substitute its previous-cycle ALU result for that operand.
REQ-015 bubble_count  out  16  saturating count of inserted bubbles.

Function
REQ-016 Operand select, per source s in {rs1, rs2}, priority: index 0 -> 0; mem_wb_en && mem_rd==index -> mem_result; wb_en && wb_rd==index -> wb_data; else id_*_data.
REQ-017 WB bypass shall cover the same-cycle register-file write, which is not visible on the read port until the next cycle.
REQ-018 EX dependency: ex_valid && ex_ctrl[0] && ex_rd_index!=0 && ex_rd_index==index && uses bit set.
REQ-019 Load-use: stall_out=1 when an EX dependency exists, id_valid=1 and ex_ctrl[1]=1; otherwise 0.
REQ-020 Non-load EX dependency: no stall; the corresponding ex_fwd_* is registered as 1 with the instruction.
REQ-021 Each clock edge, exactly one of these applies, in priority order: flush -> bubble; stall_out -> bubble (ID operands not captured, upstream holds); else capture.
REQ-022 Bubble: ex_valid<=0, ex_ctrl<=0, ex_fwd_*<=0; other fields don't-care; holding them is permitted.
REQ-023 Capture: ex_valid<=id_valid; all fields load from the ID inputs and forwarded operands; ex_ctrl<=0 when id_valid=0.
REQ-024 Latency: one cycle, ID to EX.
REQ-025 A stall shall last exactly one cycle per load-use pair; in the next cycle the load is in MEM and REQ-016 supplies the data.
REQ-026 bubble_count increments on every stall-induced bubble only (not flush), saturating at 0xFFFF.
REQ-027 flush and stall in the same cycle: bubble, counter unchanged, stall_out still asserted.

Reset
REQ-028 rst_n low: immediately ex_valid=0, ex_ctrl=0, ex_fwd_*=0, all data fields 0, bubble_count=0.
REQ-029 stall_out shall be 0 while rst_n is low.
REQ-030 A reset asserted during a stall clears it; the first edge after release captures normally.

Structure
REQ-031 Shared package holds ctrl bit-position constants, XLEN default, and NOP ctrl value 0.
REQ-032 One sub-module, operand_fwd_mux, instantiated twice, implements REQ-016 for one source.

Verification
REQ-033 x5 written via WB (wb_en=1, wb_rd=5, wb_data=0xAA) while ID reads x5 with stale regfile data 0x11 -> ex_rs1_data=0xAA.
REQ-034 MEM wants x5=0x22 and WB wants x5=0x33 in the same cycle -> 0x22 captured (MEM priority).
REQ-035 Load to x7 in EX, ID instruction uses rs2=x7 -> stall_out=1 for one cycle, bubble (ex_valid=0), bubble_count 0->1; next edge captures mem_result.
REQ-036 ADD to x3 in EX, ID uses rs1=x3 -> no stall, ex_fwd_rs1=1, ex_fwd_rs2=0.
REQ-037 rd=0 writer on all paths, ID reads x0 -> operand 0, no stall, no fwd; flush coincident with load-use -> ex_valid=0, count unchanged.
REQ-038 rst_n pulsed low mid-stall -> outputs cleared asynchronously; bubble_count preloaded 0xFFFF (via 65535 stalls) stays 0xFFFF on a further stall.
